// File: rtl/rv32i_insn_encoder_pkg.sv
// Shared RV32I encoder definitions: request kinds, opcode/funct constants and
// the small field helpers used by both the field packer and the LI expansion.
package rv32i_insn_encoder_pkg;

    typedef enum logic [4:0] {
        K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA, K_SLT, K_SLTU,
        K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI, K_SLTIU, K_SLLI, K_SRLI, K_SRAI,
        K_LW, K_SW, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
        K_JAL, K_JALR, K_LUI, K_LI, K_RSVD
    } kind_e;

    typedef enum logic [3:0] {
        FMT_R, FMT_I, FMT_SH, FMT_LD, FMT_S, FMT_B, FMT_J, FMT_JALR, FMT_U, FMT_LI, FMT_BAD
    } fmt_e;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // True when v, read as signed, fits an n-bit two's-complement field.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
        logic [31:0] t;
        t = $unsigned($signed(v) >>> (n - 1));
        return (t == 32'h0) || (t == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

endpackage

// File: rtl/rv32i_insn_encoder_if.sv
// Request/response bus of the instruction encoder; the master drives requests
// and consumes words, the slave is the encoder itself.
interface rv32i_insn_encoder_if #(parameter int ADDR_W = 32);
    logic              addr_load;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_kind;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_insn;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    modport master (
        output addr_load, req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_insn, out_addr, err
    );

    modport slave (
        input  addr_load, req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_insn, out_addr, err
    );
endinterface

// File: rtl/rv32i_field_pack.sv
// Combinational RV32I field packer: maps a request kind and its fields to one
// instruction word and flags reserved kinds or immediates that do not fit.
module rv32i_field_pack
    import rv32i_insn_encoder_pkg::*;
(
    input  logic [4:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] insn,
    output logic        range_err
);
    fmt_e       fmt;
    logic [2:0] f3;
    logic [6:0] f7;

    always_comb begin
        fmt = FMT_BAD;
        f3  = F3_ADD;
        f7  = F7_BASE;
        case (kind_e'(kind))
            K_ADD:   begin fmt = FMT_R;    f3 = F3_ADD;  end
            K_SUB:   begin fmt = FMT_R;    f3 = F3_ADD;  f7 = F7_ALT; end
            K_AND:   begin fmt = FMT_R;    f3 = F3_AND;  end
            K_OR:    begin fmt = FMT_R;    f3 = F3_OR;   end
            K_XOR:   begin fmt = FMT_R;    f3 = F3_XOR;  end
            K_SLL:   begin fmt = FMT_R;    f3 = F3_SLL;  end
            K_SRL:   begin fmt = FMT_R;    f3 = F3_SR;   end
            K_SRA:   begin fmt = FMT_R;    f3 = F3_SR;   f7 = F7_ALT; end
            K_SLT:   begin fmt = FMT_R;    f3 = F3_SLT;  end
            K_SLTU:  begin fmt = FMT_R;    f3 = F3_SLTU; end
            K_ADDI:  begin fmt = FMT_I;    f3 = F3_ADD;  end
            K_ANDI:  begin fmt = FMT_I;    f3 = F3_AND;  end
            K_ORI:   begin fmt = FMT_I;    f3 = F3_OR;   end
            K_XORI:  begin fmt = FMT_I;    f3 = F3_XOR;  end
            K_SLTI:  begin fmt = FMT_I;    f3 = F3_SLT;  end
            K_SLTIU: begin fmt = FMT_I;    f3 = F3_SLTU; end
            K_SLLI:  begin fmt = FMT_SH;   f3 = F3_SLL;  end
            K_SRLI:  begin fmt = FMT_SH;   f3 = F3_SR;   end
            K_SRAI:  begin fmt = FMT_SH;   f3 = F3_SR;   f7 = F7_ALT; end
            K_LW:    begin fmt = FMT_LD;   f3 = F3_W;    end
            K_SW:    begin fmt = FMT_S;    f3 = F3_W;    end
            K_BEQ:   begin fmt = FMT_B;    f3 = F3_BEQ;  end
            K_BNE:   begin fmt = FMT_B;    f3 = F3_BNE;  end
            K_BLT:   begin fmt = FMT_B;    f3 = F3_BLT;  end
            K_BGE:   begin fmt = FMT_B;    f3 = F3_BGE;  end
            K_BLTU:  begin fmt = FMT_B;    f3 = F3_BLTU; end
            K_BGEU:  begin fmt = FMT_B;    f3 = F3_BGEU; end
            K_JAL:   fmt = FMT_J;
            K_JALR:  begin fmt = FMT_JALR; f3 = F3_JALR; end
            K_LUI:   fmt = FMT_U;
            K_LI:    fmt = FMT_LI;
            default: fmt = FMT_BAD;
        endcase
    end

    // LI is expanded by the top level, so it packs to nothing here.
    always_comb begin
        insn      = 32'h0;
        range_err = 1'b0;
        case (fmt)
            FMT_R:    insn = {f7, rs2, rs1, f3, rd, OP_REG};
            FMT_I:    begin
                insn      = enc_i(imm[11:0], rs1, f3, rd, OP_IMM);
                range_err = !fits_signed(imm, 12);
            end
            FMT_SH:   begin
                insn      = enc_i({f7, imm[4:0]}, rs1, f3, rd, OP_IMM);
                range_err = (imm[31:5] != 27'h0);
            end
            FMT_LD:   begin
                insn      = enc_i(imm[11:0], rs1, f3, rd, OP_LOAD);
                range_err = !fits_signed(imm, 12);
            end
            FMT_S:    begin
                insn      = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
                range_err = !fits_signed(imm, 12);
            end
            FMT_B:    begin
                insn      = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
                range_err = !fits_signed(imm, 13) || imm[0];
            end
            FMT_J:    begin
                insn      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                range_err = !fits_signed(imm, 21) || imm[0];
            end
            FMT_JALR: begin
                insn      = enc_i(imm[11:0], rs1, f3, rd, OP_JALR);
                range_err = !fits_signed(imm, 12);
            end
            FMT_U:    begin
                insn      = enc_u(imm[19:0], rd, OP_LUI);
                range_err = (imm[31:20] != 12'h0);
            end
            FMT_LI:   range_err = 1'b0;
            default:  range_err = 1'b1;
        endcase
    end
endmodule

// File: rtl/rv32i_insn_encoder.sv
// RV32I instruction encoder: valid/ready request in, addressed word out, with
// LI expanded into LUI+ADDI by a two-state sequencer.
module rv32i_insn_encoder
    import rv32i_insn_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_insn_encoder_if.slave  bus
);
    typedef enum logic {S_IDLE, S_LI_LO} state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_insn_q, out_insn_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [4:0]        pend_rd_q, pend_rd_d;
    logic [11:0]       pend_lo_q, pend_lo_d;

    logic [31:0] pack_insn;
    logic        pack_err;
    logic        out_free, fire_in, fire_out;
    logic        li_small;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic        load_en;
    logic [31:0] load_word;

    rv32i_field_pack u_pack (
        .kind      (bus.req_kind),
        .rd        (bus.req_rd),
        .rs1       (bus.req_rs1),
        .rs2       (bus.req_rs2),
        .imm       (bus.req_imm),
        .insn      (pack_insn),
        .range_err (pack_err)
    );

    assign out_free = !out_valid_q || bus.out_ready;
    assign fire_in  = bus.req_valid && bus.req_ready;
    assign fire_out = out_valid_q && bus.out_ready;

    // Adding 0x800 before taking the upper bits only carries from imm[11].
    assign li_small = fits_signed(bus.req_imm, 12);
    assign li_hi    = bus.req_imm[31:12] + {19'h0, bus.req_imm[11]};
    assign li_lo    = bus.req_imm[11:0];

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_insn_d  = out_insn_q;
        out_addr_d  = out_addr_q;
        err_d       = 1'b0;
        pend_rd_d   = pend_rd_q;
        pend_lo_d   = pend_lo_q;
        load_en     = 1'b0;
        load_word   = 32'h0;

        if (bus.addr_load)
            cnt_d = BASE_ADDR;
        else if (fire_out)
            cnt_d = cnt_q + ADDR_W'(4);
        else
            cnt_d = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (fire_in) begin
                    if (bus.req_kind == K_LI) begin
                        load_en = 1'b1;
                        if (li_small) begin
                            load_word = enc_i(li_lo, 5'd0, F3_ADD, bus.req_rd, OP_IMM);
                        end else begin
                            load_word = enc_u(li_hi, bus.req_rd, OP_LUI);
                            if (li_lo != 12'h0) begin
                                state_d   = S_LI_LO;
                                pend_rd_d = bus.req_rd;
                                pend_lo_d = li_lo;
                            end
                        end
                    end else if (pack_err) begin
                        err_d = 1'b1;
                    end else begin
                        load_en   = 1'b1;
                        load_word = pack_insn;
                    end
                end
            end
            S_LI_LO: begin
                if (out_free) begin
                    load_en   = 1'b1;
                    load_word = enc_i(pend_lo_q, pend_rd_q, F3_ADD, pend_rd_q, OP_IMM);
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_en) begin
            out_valid_d = 1'b1;
            out_insn_d  = load_word;
            out_addr_d  = cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_insn_q  <= 32'h0;
            out_addr_q  <= BASE_ADDR;
            cnt_q       <= BASE_ADDR;
            err_q       <= 1'b0;
            pend_rd_q   <= 5'd0;
            pend_lo_q   <= 12'h0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_insn_q  <= out_insn_d;
            out_addr_q  <= out_addr_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            pend_rd_q   <= pend_rd_d;
            pend_lo_q   <= pend_lo_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && out_free;
    assign bus.out_valid = out_valid_q;
    assign bus.out_insn  = out_insn_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.err       = err_q;
endmodule
